// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID-stage decode, operand forwarding, branch resolution,
// load-use and mul/div stall handling, plus a saturating stall-cycle counter.
module pipe_ctrl_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int MEXT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [5*NUM_FWD-1:0]   fwd_rd_addr,
  input  logic [NUM_FWD-1:0]     fwd_wb_en,
  input  logic                   ex_is_load,
  input  logic                   md_done,
  output logic [1:0]             fwd1_sel,
  output logic [1:0]             fwd2_sel,
  output logic                   src1_pc_sel,
  output logic                   src2_imm_sel,
  output logic [3:0]             alu_ctrl,
  output logic [1:0]             mul_ctrl,
  output logic [1:0]             result_sel,
  output logic [1:0]             pc_sel,
  output logic [1:0]             instr_sel,
  output logic                   dm_web,
  output logic                   wb_en,
  output logic                   stall,
  output logic                   md_start,
  output logic                   illegal_instr,
  output logic [15:0]            stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {RUN, MD_BUSY, FLUSH} state_t;

  // store is held active-high so that reset and bubble values are both all-zero
  typedef struct packed {
    logic [1:0] fwd1;
    logic [1:0] fwd2;
    logic       src1_pc;
    logic       src2_imm;
    logic [3:0] alu;
    logic [1:0] mul;
    logic [1:0] res;
    logic [1:0] pc;
    logic       store;
    logic       wb;
    logic       md_start;
    logic       illegal;
  } dec_t;

  state_t     state, state_nxt;
  dec_t       dec_q, dec_nxt, dec_run;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       mop, illegal, hazard, br_cmp, br_taken;
  logic [4:0] ex_rd;
  logic       unused_funct7;

  assign ex_rd         = fwd_rd_addr[4:0];
  assign unused_funct7 = ^{funct7[6], funct7[4:1]};

  function automatic logic [1:0] fwd_pick(input logic [4:0] rs);
    logic found;
    found    = 1'b0;
    fwd_pick = '0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!found && fwd_wb_en[k] && (fwd_rd_addr[5*k +: 5] == rs) &&
          (fwd_rd_addr[5*k +: 5] != 5'd0)) begin
        fwd_pick = 2'(k + 1);
        found    = 1'b1;
      end
    end
  endfunction

  always_comb begin
    is_r      = (opcode == OP_R);
    is_imm    = (opcode == OP_IMM);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_lui    = (opcode == OP_LUI);
    is_auipc  = (opcode == OP_AUIPC);
    mop       = is_r && funct7[0];
    illegal   = !(is_r || is_imm || is_load || is_store || is_branch ||
                  is_jal || is_jalr || is_lui || is_auipc) || (mop && (MEXT == 0));
    hazard    = ex_is_load && (ex_rd != 5'd0) &&
                ((ex_rd == rs1_addr) ||
                 ((ex_rd == rs2_addr) && (is_r || is_store || is_branch)));
    case (funct3[2:1])
      2'b00:   br_cmp = (rs1_data == rs2_data);
      2'b10:   br_cmp = ($signed(rs1_data) < $signed(rs2_data));
      2'b11:   br_cmp = (rs1_data < rs2_data);
      default: br_cmp = 1'b0;
    endcase
    br_taken  = is_branch && (funct3[2:1] != 2'b01) && (br_cmp ^ funct3[0]);
  end

  always_comb begin
    dec_run = '0;
    if (illegal) begin
      dec_run.illegal = 1'b1;
    end else begin
      dec_run.fwd1 = fwd_pick(rs1_addr);
      dec_run.fwd2 = fwd_pick(rs2_addr);
      if (is_r || (is_imm && (funct3[1:0] == 2'b01)))
        dec_run.alu = {funct7[5], funct3};
      else if (is_imm)
        dec_run.alu = {1'b0, funct3};
      else if (is_lui)
        dec_run.alu = 4'b1001;
      dec_run.mul      = mop ? funct3[1:0] : 2'd0;
      dec_run.src1_pc  = is_branch || is_auipc || is_jal;
      dec_run.src2_imm = !is_r;
      dec_run.res      = (is_jal || is_jalr) ? 2'd2 : (mop ? 2'd1 : 2'd0);
      dec_run.store    = is_store;
      dec_run.wb       = !(is_branch || is_store);
      dec_run.pc       = {1'b0, is_jal || is_jalr || br_taken};
      dec_run.md_start = mop;
    end
  end

  // The md_done edge decodes without a load-use check: stall is already low there.
  always_comb begin
    state_nxt        = state;
    dec_nxt          = dec_q;
    dec_nxt.md_start = 1'b0;
    dec_nxt.illegal  = 1'b0;
    stall            = 1'b0;
    unique case (state)
      MD_BUSY: begin
        stall = !md_done;
        if (md_done) begin
          dec_nxt   = dec_run;
          state_nxt = dec_run.pc[0] ? FLUSH : (dec_run.md_start ? MD_BUSY : RUN);
        end
      end
      FLUSH: begin
        dec_nxt   = '0;
        state_nxt = RUN;
      end
      default: begin
        if (hazard) begin
          stall   = 1'b1;
          dec_nxt = '0;
        end else begin
          dec_nxt   = dec_run;
          state_nxt = dec_run.pc[0] ? FLUSH : (dec_run.md_start ? MD_BUSY : RUN);
        end
      end
    endcase
    stall = stall && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      dec_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      dec_q <= dec_nxt;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign instr_sel     = (state == FLUSH) ? 2'd2 : 2'd0;
  assign fwd1_sel      = dec_q.fwd1;
  assign fwd2_sel      = dec_q.fwd2;
  assign src1_pc_sel   = dec_q.src1_pc;
  assign src2_imm_sel  = dec_q.src2_imm;
  assign alu_ctrl      = dec_q.alu;
  assign mul_ctrl      = dec_q.mul;
  assign result_sel    = dec_q.res;
  assign pc_sel        = dec_q.pc;
  assign dm_web        = !dec_q.store;
  assign wb_en         = dec_q.wb;
  assign md_start      = dec_q.md_start;
  assign illegal_instr = dec_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized
// instruction streams checked against a cycle-level behavioural model.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic       pcs;
    logic       imms;
    logic [3:0] alu;
    logic [1:0] mul;
    logic [1:0] res;
    logic [1:0] pc;
    logic       web;
    logic       wb;
    logic       mds;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;
    logic       pcs;
    logic       imm;
    logic [1:0] res;
    logic       web;
    logic       wb;
  } row_t;

  int nvec = 0;
  int nerr = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [14:0] fwd_rd_addr;
  logic [2:0]  fwd_wb_en;
  logic        ex_is_load, md_done;

  logic [1:0]  fwd1_sel, fwd2_sel, mul_ctrl, result_sel, pc_sel, instr_sel;
  logic        src1_pc_sel, src2_imm_sel, dm_web, wb_en, stall, md_start, illegal_instr;
  logic [3:0]  alu_ctrl;
  logic [15:0] stall_cnt;

  logic [1:0]  nm_fwd1_sel, nm_fwd2_sel, nm_mul_ctrl, nm_result_sel, nm_pc_sel, nm_instr_sel;
  logic        nm_src1_pc_sel, nm_src2_imm_sel, nm_dm_web, nm_wb_en, nm_stall, nm_md_start;
  logic        nm_illegal_instr;
  logic [3:0]  nm_alu_ctrl;
  logic [15:0] nm_stall_cnt;

  logic [6:0]  ops [11] = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67,
                            7'h37, 7'h17, 7'h7f};
  logic [2:0]  bf3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] dv  [6]  = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd7};
  row_t        rows [8] = '{
    '{7'h33, 3'd0, 7'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1},
    '{7'h33, 3'd0, 7'h20, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1},
    '{7'h13, 3'd5, 7'h20, 4'b1101, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1},
    '{7'h13, 3'd7, 7'h20, 4'b0111, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1},
    '{7'h37, 3'd0, 7'h00, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1},
    '{7'h17, 3'd0, 7'h00, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1},
    '{7'h03, 3'd2, 7'h00, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1},
    '{7'h23, 3'd2, 7'h00, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}};

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.XLEN(32), .NUM_FWD(3), .MEXT(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rd_addr(fwd_rd_addr), .fwd_wb_en(fwd_wb_en), .ex_is_load(ex_is_load),
    .md_done(md_done), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .src1_pc_sel(src1_pc_sel), .src2_imm_sel(src2_imm_sel), .alu_ctrl(alu_ctrl),
    .mul_ctrl(mul_ctrl), .result_sel(result_sel), .pc_sel(pc_sel), .instr_sel(instr_sel),
    .dm_web(dm_web), .wb_en(wb_en), .stall(stall), .md_start(md_start),
    .illegal_instr(illegal_instr), .stall_cnt(stall_cnt));

  pipe_ctrl_unit #(.XLEN(32), .NUM_FWD(3), .MEXT(0)) dut_nm (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rd_addr(fwd_rd_addr), .fwd_wb_en(fwd_wb_en), .ex_is_load(ex_is_load),
    .md_done(md_done), .fwd1_sel(nm_fwd1_sel), .fwd2_sel(nm_fwd2_sel),
    .src1_pc_sel(nm_src1_pc_sel), .src2_imm_sel(nm_src2_imm_sel), .alu_ctrl(nm_alu_ctrl),
    .mul_ctrl(nm_mul_ctrl), .result_sel(nm_result_sel), .pc_sel(nm_pc_sel),
    .instr_sel(nm_instr_sel), .dm_web(nm_dm_web), .wb_en(nm_wb_en), .stall(nm_stall),
    .md_start(nm_md_start), .illegal_instr(nm_illegal_instr), .stall_cnt(nm_stall_cnt));

  function automatic exp_t got_main();
    got_main = {fwd1_sel, fwd2_sel, src1_pc_sel, src2_imm_sel, alu_ctrl, mul_ctrl,
                result_sel, pc_sel, dm_web, wb_en, md_start, illegal_instr};
  endfunction

  function automatic exp_t bubble();
    bubble     = '0;
    bubble.web = 1'b1;
  endfunction

  function automatic logic [1:0] m_fsel(input logic [4:0] r, input logic [14:0] fa,
                                        input logic [2:0] fe);
    logic [4:0] rds [3];
    rds[0] = fa[4:0];
    rds[1] = fa[9:5];
    rds[2] = fa[14:10];
    for (int k = 0; k < 3; k++)
      if (fe[k] && (r != 5'd0) && (rds[k] == r)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic exp_t model_dec(input bit mext);
    exp_t e;
    bit   t;
    e = bubble();
    if (!(opcode inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17}) ||
        (opcode == 7'h33 && funct7[0] && !mext)) begin
      e.ill = 1'b1;
      return e;
    end
    e.f1   = m_fsel(rs1_addr, fwd_rd_addr, fwd_wb_en);
    e.f2   = m_fsel(rs2_addr, fwd_rd_addr, fwd_wb_en);
    e.imms = 1'b1;
    e.wb   = 1'b1;
    case (opcode)
      7'h33: begin
        e.alu  = {funct7[5], funct3};
        e.imms = 1'b0;
        if (funct7[0]) begin
          e.res = 2'd1;
          e.mul = funct3[1:0];
          e.mds = 1'b1;
        end
      end
      7'h13: e.alu = (funct3 == 3'd1 || funct3 == 3'd5) ? {funct7[5], funct3} : {1'b0, funct3};
      7'h23: begin e.web = 1'b0; e.wb = 1'b0; end
      7'h63: begin
        case (funct3)
          3'd0: t = (rs1_data == rs2_data);
          3'd1: t = (rs1_data != rs2_data);
          3'd4: t = ($signed(rs1_data) <  $signed(rs2_data));
          3'd5: t = ($signed(rs1_data) >= $signed(rs2_data));
          3'd6: t = (rs1_data <  rs2_data);
          3'd7: t = (rs1_data >= rs2_data);
          default: t = 1'b0;
        endcase
        e.pcs = 1'b1;
        e.wb  = 1'b0;
        e.pc  = t ? 2'd1 : 2'd0;
      end
      7'h6f: begin e.pcs = 1'b1; e.res = 2'd2; e.pc = 2'd1; end
      7'h67: begin e.res = 2'd2; e.pc = 2'd1; end
      7'h37: e.alu = 4'b1001;
      7'h17: e.pcs = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] r1, input logic [4:0] r2);
    opcode = op; funct3 = f3; funct7 = f7; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic idle_inputs();
    set_instr(7'h13, 3'd0, 7'h00, 5'd0, 5'd0);
    rs1_data = '0; rs2_data = '0; fwd_rd_addr = '0; fwd_wb_en = '0;
    ex_is_load = 1'b0; md_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    nvec++;
    if (got_main() !== bubble() || stall_cnt !== 16'd0 || instr_sel !== 2'd0) begin
      nerr++;
      $display("FAIL reset_async: outputs %h cnt %h, want %h cnt 0", got_main(), stall_cnt, bubble());
    end
    set_instr(7'h33, 3'd0, 7'h00, 5'd4, 5'd4);
    fwd_rd_addr = 15'd4; ex_is_load = 1'b1;
    step();
    nvec++;
    if (got_main() !== bubble() || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_held: outputs %h stall %b cnt %h, want %h stall 0 cnt 0",
               got_main(), stall, stall_cnt, bubble());
    end
    do_reset();
  endtask

  task automatic test_forward();
    set_instr(7'h33, 3'd0, 7'h00, 5'd1, 5'd2);
    fwd_rd_addr = {5'd0, 5'd2, 5'd1}; fwd_wb_en = 3'b011;
    step();
    nvec++;
    if (fwd1_sel !== 2'd1 || fwd2_sel !== 2'd2 || alu_ctrl !== 4'b0000 || wb_en !== 1'b1) begin
      nerr++;
      $display("FAIL fwd_add: f1 %0d f2 %0d alu %b wb %b, want 1 2 0000 1",
               fwd1_sel, fwd2_sel, alu_ctrl, wb_en);
    end
    set_instr(7'h33, 3'd0, 7'h00, 5'd1, 5'd0);
    fwd_rd_addr = {5'd1, 5'd1, 5'd0}; fwd_wb_en = 3'b111;
    step();
    nvec++;
    if (fwd1_sel !== 2'd2 || fwd2_sel !== 2'd0) begin
      nerr++;
      $display("FAIL fwd_prio: f1 %0d f2 %0d, want 2 0", fwd1_sel, fwd2_sel);
    end
    fwd_rd_addr = {5'd1, 5'd0, 5'd0}; fwd_wb_en = 3'b011;
    step();
    nvec++;
    if (fwd1_sel !== 2'd0) begin
      nerr++;
      $display("FAIL fwd_disabled: f1 %0d, want 0", fwd1_sel);
    end
    fwd_rd_addr = '0; fwd_wb_en = '0;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 8; i++) begin
      set_instr(rows[i].op, rows[i].f3, rows[i].f7, 5'd1, 5'd2);
      step();
      nvec++;
      if (alu_ctrl !== rows[i].alu || src1_pc_sel !== rows[i].pcs ||
          src2_imm_sel !== rows[i].imm || result_sel !== rows[i].res ||
          dm_web !== rows[i].web || wb_en !== rows[i].wb) begin
        nerr++;
        $display("FAIL decode_row%0d: alu %b pcs %b imm %b res %0d web %b wb %b, want %b %b %b %0d %b %b",
                 i, alu_ctrl, src1_pc_sel, src2_imm_sel, result_sel, dm_web, wb_en,
                 rows[i].alu, rows[i].pcs, rows[i].imm, rows[i].res, rows[i].web, rows[i].wb);
      end
    end
  endtask

  task automatic test_branch();
    set_instr(7'h63, 3'd1, 7'h00, 5'd5, 5'd6);
    rs1_data = 32'd5; rs2_data = 32'd7;
    step();
    nvec++;
    if (pc_sel !== 2'd1 || instr_sel !== 2'd2) begin
      nerr++;
      $display("FAIL bne_taken: pc_sel %0d instr_sel %0d, want 1 2", pc_sel, instr_sel);
    end
    set_instr(7'h33, 3'd0, 7'h00, 5'd1, 5'd2);
    step();
    nvec++;
    if (wb_en !== 1'b0 || pc_sel !== 2'd0 || instr_sel !== 2'd0) begin
      nerr++;
      $display("FAIL flush_bubble: wb %b pc_sel %0d instr_sel %0d, want 0 0 0", wb_en, pc_sel, instr_sel);
    end
    set_instr(7'h63, 3'd1, 7'h00, 5'd5, 5'd6);
    rs2_data = 32'd5;
    step();
    nvec++;
    if (pc_sel !== 2'd0 || instr_sel !== 2'd0) begin
      nerr++;
      $display("FAIL bne_equal: pc_sel %0d instr_sel %0d, want 0 0", pc_sel, instr_sel);
    end
    set_instr(7'h63, 3'd6, 7'h00, 5'd5, 5'd6);
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    step();
    nvec++;
    if (pc_sel !== 2'd0) begin
      nerr++;
      $display("FAIL bltu_not_taken: pc_sel %0d, want 0", pc_sel);
    end
    funct3 = 3'd4;
    step();
    nvec++;
    if (pc_sel !== 2'd1 || instr_sel !== 2'd2) begin
      nerr++;
      $display("FAIL blt_taken: pc_sel %0d instr_sel %0d, want 1 2", pc_sel, instr_sel);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(7'h23, 3'd2, 7'h00, 5'd1, 5'd4);
    fwd_rd_addr = 15'd4; ex_is_load = 1'b1;
    #1;
    nvec++;
    if (stall !== 1'b1) begin
      nerr++;
      $display("FAIL load_use_stall: stall %b, want 1", stall);
    end
    step();
    nvec++;
    if (dm_web !== 1'b1 || wb_en !== 1'b0 || stall_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL load_use_bubble: web %b wb %b cnt %0d, want 1 0 1", dm_web, wb_en, stall_cnt);
    end
    ex_is_load = 1'b0;
    #1;
    step();
    nvec++;
    if (dm_web !== 1'b0 || stall_cnt !== 16'd1) begin
      nerr++;
      $display("FAIL load_use_resume: web %b cnt %0d, want 0 1", dm_web, stall_cnt);
    end
    set_instr(7'h13, 3'd0, 7'h00, 5'd1, 5'd4);
    ex_is_load = 1'b1;
    #1;
    nvec++;
    if (stall !== 1'b0) begin
      nerr++;
      $display("FAIL load_use_itype_rs2: stall %b, want 0", stall);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_mul();
    do_reset();
    set_instr(7'h33, 3'd3, 7'h01, 5'd1, 5'd2);
    step();
    nvec++;
    if (md_start !== 1'b1 || mul_ctrl !== 2'd3 || result_sel !== 2'd1 || wb_en !== 1'b1) begin
      nerr++;
      $display("FAIL mul_start: md_start %b mul %0d res %0d wb %b, want 1 3 1 1",
               md_start, mul_ctrl, result_sel, wb_en);
    end
    nvec++;
    if (nm_illegal_instr !== 1'b1 || nm_md_start !== 1'b0 || nm_wb_en !== 1'b0) begin
      nerr++;
      $display("FAIL nomext_illegal: ill %b md_start %b wb %b, want 1 0 0",
               nm_illegal_instr, nm_md_start, nm_wb_en);
    end
    set_instr(7'h33, 3'd0, 7'h00, 5'd3, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++;
      if (stall !== 1'b1 || nm_stall !== 1'b0) begin
        nerr++;
        $display("FAIL mul_busy_stall%0d: stall %b nm_stall %b, want 1 0", i, stall, nm_stall);
      end
      step();
      nvec++;
      if (md_start !== 1'b0 || mul_ctrl !== 2'd3 || result_sel !== 2'd1 || nm_illegal_instr !== 1'b0) begin
        nerr++;
        $display("FAIL mul_hold%0d: md_start %b mul %0d res %0d nm_ill %b, want 0 3 1 0",
                 i, md_start, mul_ctrl, result_sel, nm_illegal_instr);
      end
    end
    md_done = 1'b1;
    #1;
    nvec++;
    if (stall !== 1'b0) begin
      nerr++;
      $display("FAIL mul_done_stall: stall %b, want 0", stall);
    end
    step();
    md_done = 1'b0;
    nvec++;
    if (result_sel !== 2'd0 || mul_ctrl !== 2'd0 || md_start !== 1'b0 || stall_cnt !== 16'd3 ||
        nm_stall_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL mul_resume: res %0d mul %0d md_start %b cnt %0d nm_cnt %0d, want 0 0 0 3 0",
               result_sel, mul_ctrl, md_start, stall_cnt, nm_stall_cnt);
    end
  endtask

  task automatic test_md_reset();
    do_reset();
    set_instr(7'h33, 3'd0, 7'h01, 5'd1, 5'd2);
    step();
    set_instr(7'h33, 3'd0, 7'h00, 5'd1, 5'd2);
    step();
    #2 rst = 1'b0;
    #1;
    nvec++;
    if (got_main() !== bubble() || stall !== 1'b0 || stall_cnt !== 16'd0 || instr_sel !== 2'd0) begin
      nerr++;
      $display("FAIL md_reset: outputs %h stall %b cnt %0d, want %h 0 0",
               got_main(), stall, stall_cnt, bubble());
    end
    step();
    rst = 1'b1;
    step();
    nvec++;
    if (wb_en !== 1'b1 || result_sel !== 2'd0 || md_start !== 1'b0 || stall !== 1'b0) begin
      nerr++;
      $display("FAIL md_reset_resume: wb %b res %0d md_start %b stall %b, want 1 0 0 0",
               wb_en, result_sel, md_start, stall);
    end
  endtask

  task automatic test_flush_squash();
    do_reset();
    set_instr(7'h6f, 3'd0, 7'h00, 5'd0, 5'd0);
    step();
    set_instr(7'h33, 3'd0, 7'h01, 5'd4, 5'd2);
    fwd_rd_addr = 15'd4; ex_is_load = 1'b1;
    #1;
    nvec++;
    if (stall !== 1'b0 || instr_sel !== 2'd2) begin
      nerr++;
      $display("FAIL squash_comb: stall %b instr_sel %0d, want 0 2", stall, instr_sel);
    end
    step();
    nvec++;
    if (md_start !== 1'b0 || wb_en !== 1'b0 || pc_sel !== 2'd0 || instr_sel !== 2'd0) begin
      nerr++;
      $display("FAIL squash_bubble: md_start %b wb %b pc %0d isel %0d, want 0 0 0 0",
               md_start, wb_en, pc_sel, instr_sel);
    end
    idle_inputs();
    set_instr(7'h7f, 3'd0, 7'h00, 5'd0, 5'd0);
    step();
    nvec++;
    if (illegal_instr !== 1'b1 || wb_en !== 1'b0 || dm_web !== 1'b1) begin
      nerr++;
      $display("FAIL unknown_op: ill %b wb %b web %b, want 1 0 1", illegal_instr, wb_en, dm_web);
    end
    idle_inputs();
    step();
    nvec++;
    if (illegal_instr !== 1'b0 || wb_en !== 1'b1) begin
      nerr++;
      $display("FAIL unknown_op_clear: ill %b wb %b, want 0 1", illegal_instr, wb_en);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_instr(7'h33, 3'd0, 7'h01, 5'd1, 5'd2);
    step();
    idle_inputs();
    repeat (65535) @(posedge clk);
    #1;
    nvec++;
    if (stall_cnt !== 16'hFFFF || stall !== 1'b1) begin
      nerr++;
      $display("FAIL sat_reach: cnt %h stall %b, want ffff 1", stall_cnt, stall);
    end
    repeat (4) step();
    nvec++;
    if (stall_cnt !== 16'hFFFF || result_sel !== 2'd1) begin
      nerr++;
      $display("FAIL sat_hold: cnt %h res %0d, want ffff 1", stall_cnt, result_sel);
    end
    md_done = 1'b1;
    step();
    md_done = 1'b0;
  endtask

  task automatic test_random(input int n);
    exp_t        e, d;
    bit          busy, flush, hz, es;
    logic [1:0]  ei;
    logic [15:0] cnt;
    logic [4:0]  ex_rd;
    do_reset();
    e = bubble(); busy = 1'b0; flush = 1'b0; cnt = '0;
    for (int i = 0; i < n; i++) begin
      opcode = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 15) == 0) opcode = 7'($urandom);
      funct3 = (opcode == 7'h63) ? bf3[$urandom_range(0, 5)] : 3'($urandom);
      funct7 = 7'($urandom) & 7'h21;
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rs1_data = dv[$urandom_range(0, 5)];
      rs2_data = ($urandom_range(0, 1) == 0) ? rs1_data : dv[$urandom_range(0, 5)];
      for (int k = 0; k < 3; k++) fwd_rd_addr[5*k +: 5] = 5'($urandom_range(0, 7));
      fwd_wb_en  = 3'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      md_done    = ($urandom_range(0, 2) == 0);
      #1;
      ex_rd = fwd_rd_addr[4:0];
      hz = ex_is_load && ex_rd != 5'd0 && (ex_rd == rs1_addr ||
           (ex_rd == rs2_addr && (opcode inside {7'h33, 7'h23, 7'h63})));
      es = busy ? !md_done : (!flush && hz);
      ei = flush ? 2'd2 : 2'd0;
      nvec++;
      if (stall !== es || instr_sel !== ei) begin
        nerr++;
        $display("FAIL rand_comb cyc %0d: stall %b isel %0d, want %b %0d", i, stall, instr_sel, es, ei);
      end
      d = model_dec(1'b1);
      if (es && cnt != 16'hFFFF) cnt = cnt + 16'd1;
      if (busy && !md_done) begin
        e.mds = 1'b0;
        e.ill = 1'b0;
      end else if (flush) begin
        e = bubble();
        flush = 1'b0;
      end else if (!busy && hz) begin
        e = bubble();
      end else begin
        e = d;
        busy  = d.mds;
        flush = (d.pc == 2'd1);
      end
      step();
      nvec++;
      if (got_main() !== e || stall_cnt !== cnt) begin
        nerr++;
        $display("FAIL rand_reg cyc %0d: outputs %h cnt %0d, want %h cnt %0d",
                 i, got_main(), stall_cnt, e, cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_decode();
    test_branch();
    test_load_use();
    test_mul();
    test_md_reset();
    test_flush_squash();
    test_saturate();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
